// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types and constants for the mult/div issue controller
package md_pkg;

    // Issue-controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAP  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Operation select carried on op_div / md_set_md
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Default unit latencies in active start edges
    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 33;

    // Cycle counter width; latencies must stay below 2**CNT_W
    localparam int CNT_W = 6;

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - architectural HI/LO pair with direct-write and result-capture muxing
module hilo_regs
    import md_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        idle_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    input  logic        cap_en_i,
    input  logic [31:0] cap_hi_i,
    input  logic [31:0] cap_lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Next-state select: a unit result wins, direct mthi/mtlo only land while idle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_en_i) begin
            hi_d = cap_hi_i;
            lo_d = cap_lo_i;
        end else if (idle_i) begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - mult/div issue FSM and HI/LO ownership; DIVZERO_ABORT_EN short-circuits zero-divisor divides
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_div,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        busy,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_start,
    output logic        md_set_md,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        md_zero
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             md_start_q;
    logic             md_set_md_q;
    logic [31:0]      md_a_q;
    logic [31:0]      md_b_q;
    logic             ack_q;
    logic             div_zero_q;

    logic [CNT_W-1:0] cnt_last;
    logic             cap_en;

    assign cnt_last = (md_set_md_q == OP_DIV) ? DIV_LAST : MULT_LAST;
    // A zero-divisor divide leaves HI/LO alone; everything else captures the unit result
    assign cap_en   = (state_q == ST_CAP) && !((md_set_md_q == OP_DIV) && md_zero);

    // Issue FSM: latch operands, hold start for N+1 cycles, capture, pulse ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            md_start_q  <= 1'b0;
            md_set_md_q <= 1'b0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            ack_q       <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        md_set_md_q <= op_div;
                        md_a_q      <= src_a;
                        md_b_q      <= src_b;
                        cnt_q       <= '0;
                        div_zero_q  <= 1'b0;
`ifdef DIVZERO_ABORT_EN
                        if ((op_div == OP_DIV) && (src_b == '0)) begin
                            div_zero_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            md_start_q <= 1'b1;
                            state_q    <= ST_RUN;
                        end
`else
                        md_start_q <= 1'b1;
                        state_q    <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    if (cnt_q == cnt_last) begin
                        state_q <= ST_CAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CAP: begin
                    if ((md_set_md_q == OP_DIV) && md_zero) begin
                        div_zero_q <= 1'b1;
                    end
                    md_start_q <= 1'b0;
                    ack_q      <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
`ifdef DIVZERO_ABORT_EN
                    // Aborted divides arrive here with ack low and wait one extra edge
                    if (!ack_q) begin
                        if (cnt_q == CNT_W'(1)) begin
                            ack_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`else
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    hilo_regs u_hilo_regs (
        .clk_i    (clk),
        .reset_i  (reset),
        .idle_i   (state_q == ST_IDLE),
        .hi_we_i  (hi_we),
        .lo_we_i  (lo_we),
        .wdata_i  (wdata),
        .cap_en_i (cap_en),
        .cap_hi_i (md_hi),
        .cap_lo_i (md_lo),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    assign ack       = ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign div_zero  = div_zero_q;
    assign md_start  = md_start_q;
    assign md_set_md = md_set_md_q;
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;

endmodule
